// File: rtl/ps2_atom_keyboard.sv
// ps2_atom_keyboard: PS/2 set-2 receiver that maintains the Atom 10x6 key matrix and modifier lines.
// Optional macro PS2_EXTENDED_KEYS_EN enables mapping of E0-prefixed codes (cursor keys, right ctrl).
module ps2_atom_keyboard #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] row,
    output logic [5:0] keyboard,
    output logic       shift_n,
    output logic       ctrl_n,
    output logic       rept_n,
    output logic       break_n,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_SHL  = 3'd1;
    localparam logic [2:0] M_SHR  = 3'd2;
    localparam logic [2:0] M_CTL  = 3'd3;
    localparam logic [2:0] M_CTR  = 3'd4;
    localparam logic [2:0] M_REPT = 3'd5;
    localparam logic [2:0] M_BRK  = 3'd6;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic [FW-1:0] flt_cnt;
    logic          clk_flt, strobe;
    state_t        state, state_nx;
    logic [7:0]    sh, sh_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic          err_nx, done_nx, byte_ok;
    logic          ext, rel;
    logic [7:0]    key;
    logic [2:0]    mod;
    logic [5:0]    mods;
    logic [5:0]    matrix [0:9];

    // Two-flop synchronisers for both PS/2 pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Accept a new ps2_clk level only after FILTER_LEN consecutive differing samples; strobe on accepted fall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt_cnt <= '0;
            clk_flt <= 1'b1;
            strobe  <= 1'b0;
        end else begin
            strobe <= (clk_sync[1] != clk_flt) && (flt_cnt == FW'(FILTER_LEN - 1)) && clk_flt;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                flt_cnt <= '0;
                clk_flt <= clk_sync[1];
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Receiver next-state: start, 8 data bits LSB first, odd parity, stop; idle timeout abandons a frame
    always_comb begin
        state_nx   = state;
        sh_nx      = sh;
        bit_cnt_nx = bit_cnt;
        tmo_nx     = '0;
        err_nx     = 1'b0;
        done_nx    = 1'b0;
        if (state != IDLE && !strobe) begin
            tmo_nx = tmo + 1'b1;
            if (tmo == TW'(TIMEOUT - 1)) begin
                state_nx = IDLE;
                tmo_nx   = '0;
            end
        end
        if (strobe) begin
            case (state)
                IDLE: begin
                    state_nx   = data_sync[1] ? IDLE : DATA;
                    bit_cnt_nx = '0;
                end
                DATA: begin
                    sh_nx      = {data_sync[1], sh[7:1]};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    state_nx   = (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    state_nx = (^{sh, data_sync[1]}) ? STOP : IDLE;
                    err_nx   = ~(^{sh, data_sync[1]});
                end
                STOP: begin
                    state_nx = IDLE;
                    done_nx  = data_sync[1];
                    err_nx   = ~data_sync[1];
                end
            endcase
        end
    end

    // Receiver state register; frame_err and byte_ok are single-cycle pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh        <= '0;
            bit_cnt   <= '0;
            tmo       <= '0;
            frame_err <= 1'b0;
            byte_ok   <= 1'b0;
        end else begin
            state     <= state_nx;
            sh        <= sh_nx;
            bit_cnt   <= bit_cnt_nx;
            tmo       <= tmo_nx;
            frame_err <= err_nx;
            byte_ok   <= done_nx;
        end
    end

    // Scancode to Atom matrix cell {valid,row,col} or modifier
    always_comb begin
        key = '0;
        mod = M_NONE;
        if (!ext) begin
            case (sh)
                8'h12: mod = M_SHL;
                8'h59: mod = M_SHR;
                8'h14: mod = M_CTL;
                8'h11: mod = M_REPT;
                8'h09: mod = M_BRK;
                8'h29: key = {1'b1, 4'd9, 3'd0};
                8'h5A: key = {1'b1, 4'd6, 3'd1};
                8'h1C: key = {1'b1, 4'd1, 3'd5};
                8'h32: key = {1'b1, 4'd0, 3'd3};
                8'h21: key = {1'b1, 4'd1, 3'd3};
                8'h23: key = {1'b1, 4'd2, 3'd3};
                8'h24: key = {1'b1, 4'd3, 3'd3};
                8'h2B: key = {1'b1, 4'd4, 3'd3};
                8'h34: key = {1'b1, 4'd5, 3'd3};
                8'h33: key = {1'b1, 4'd6, 3'd3};
                8'h43: key = {1'b1, 4'd7, 3'd3};
                8'h3B: key = {1'b1, 4'd8, 3'd3};
                8'h42: key = {1'b1, 4'd9, 3'd3};
                8'h4B: key = {1'b1, 4'd0, 3'd2};
                8'h3A: key = {1'b1, 4'd1, 3'd2};
                8'h31: key = {1'b1, 4'd2, 3'd2};
                8'h44: key = {1'b1, 4'd3, 3'd2};
                8'h4D: key = {1'b1, 4'd4, 3'd2};
                8'h15: key = {1'b1, 4'd5, 3'd2};
                8'h2D: key = {1'b1, 4'd6, 3'd2};
                8'h1B: key = {1'b1, 4'd7, 3'd2};
                8'h2C: key = {1'b1, 4'd8, 3'd2};
                8'h3C: key = {1'b1, 4'd9, 3'd2};
                8'h2A: key = {1'b1, 4'd4, 3'd4};
                8'h1D: key = {1'b1, 4'd5, 3'd4};
                8'h22: key = {1'b1, 4'd6, 3'd4};
                8'h35: key = {1'b1, 4'd7, 3'd4};
                8'h1A: key = {1'b1, 4'd8, 3'd4};
                8'h45: key = {1'b1, 4'd0, 3'd0};
                8'h16: key = {1'b1, 4'd1, 3'd0};
                8'h1E: key = {1'b1, 4'd2, 3'd0};
                8'h26: key = {1'b1, 4'd3, 3'd0};
                8'h25: key = {1'b1, 4'd4, 3'd0};
                8'h2E: key = {1'b1, 4'd5, 3'd0};
                8'h36: key = {1'b1, 4'd6, 3'd0};
                8'h3D: key = {1'b1, 4'd7, 3'd0};
                8'h3E: key = {1'b1, 4'd8, 3'd0};
                8'h46: key = {1'b1, 4'd0, 3'd1};
                default: key = '0;
            endcase
        end
`ifdef PS2_EXTENDED_KEYS_EN
        else begin
            case (sh)
                8'h14: mod = M_CTR;
                8'h75: key = {1'b1, 4'd3, 3'd5};
                8'h72: key = {1'b1, 4'd3, 3'd4};
                8'h6B: key = {1'b1, 4'd2, 3'd5};
                8'h74: key = {1'b1, 4'd2, 3'd4};
                default: key = '0;
            endcase
        end
`endif
    end

    // Apply each accepted byte: prefixes set flags, overflow clears everything, other codes make/release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext  <= 1'b0;
            rel  <= 1'b0;
            mods <= '0;
            for (int i = 0; i < 10; i++) matrix[i] <= '0;
        end else if (byte_ok) begin
            if (sh == 8'hE0) begin
                ext <= 1'b1;
            end else if (sh == 8'hF0) begin
                rel <= 1'b1;
            end else if (sh == 8'hAA || sh == 8'hFA) begin
                ext <= ext;
            end else if (sh == 8'h00 || sh == 8'hFF) begin
                ext  <= 1'b0;
                rel  <= 1'b0;
                mods <= '0;
                for (int i = 0; i < 10; i++) matrix[i] <= '0;
            end else begin
                ext <= 1'b0;
                rel <= 1'b0;
                if (key[7]) matrix[key[6:3]][key[2:0]] <= ~rel;
                if (mod != M_NONE) mods[mod - 3'd1] <= ~rel;
            end
        end else if (frame_err) begin
            ext <= 1'b0;
            rel <= 1'b0;
        end
    end

    assign keyboard = (row <= 4'd9) ? ~matrix[row] : 6'h3F;
    assign shift_n  = ~(mods[0] | mods[1]);
    assign ctrl_n   = ~(mods[2] | mods[3]);
    assign rept_n   = ~mods[4];
    assign break_n  = ~mods[5];
endmodule

// File: tb/tb_ps2_atom_keyboard.sv
// tb_ps2_atom_keyboard: vector table, corner-case sequences and randomized key traffic against a held-key model.
module tb_ps2_atom_keyboard;
`ifdef PS2_EXTENDED_KEYS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] row = 4'd0;
    logic [5:0] keyboard;
    logic       shift_n, ctrl_n, rept_n, break_n, frame_err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;

    typedef struct {
        logic [7:0] code;
        bit         badp;
        logic [3:0] r;
        logic [5:0] kb;
        logic [3:0] mods;
        int         errd;
    } vec_t;

    vec_t tbl[$];
    bit   held[int];
    bit   mext, mrel;

    ps2_atom_keyboard dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .row(row),
        .keyboard(keyboard), .shift_n(shift_n), .ctrl_n(ctrl_n), .rept_n(rept_n),
        .break_n(break_n), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) err_seen++;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(bit b);
        ps2_data = b;
        cyc(4);
        ps2_clk = 1'b0;
        cyc(8);
        ps2_clk = 1'b1;
        cyc(4);
    endtask

    task automatic send(logic [7:0] b, bit badp = 1'b0, int nbits = 11);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ badp, b, 1'b0};
        for (int i = 0; i < nbits; i++) bit_out(f[i]);
        ps2_data = 1'b1;
        cyc(12);
    endtask

    task automatic read_rows(output logic [71:0] v);
        for (int r = 0; r < 12; r++) begin
            row = 4'(r);
            #1;
            v[r*6 +: 6] = keyboard;
            cyc(1);
        end
    endtask

    function automatic void add(logic [7:0] code, bit badp, logic [3:0] r, logic [5:0] kb, logic [3:0] mods, int errd);
        vec_t t;
        t.code = code; t.badp = badp; t.r = r; t.kb = kb; t.mods = mods; t.errd = errd;
        tbl.push_back(t);
    endfunction

    // held-key id: row*6+col for matrix keys, 100.. for modifiers, -1 for unmapped
    function automatic int lookup(bit e, logic [7:0] c);
        if (e) begin
`ifdef PS2_EXTENDED_KEYS_EN
            case (c)
                8'h14: return 103;
                8'h75: return 3*6 + 5;
                8'h72: return 3*6 + 4;
                8'h6B: return 2*6 + 5;
                8'h74: return 2*6 + 4;
                default: return -1;
            endcase
`else
            return -1;
`endif
        end
        case (c)
            8'h1C: return 1*6 + 5;
            8'h29: return 9*6 + 0;
            8'h5A: return 6*6 + 1;
            8'h32: return 0*6 + 3;
            8'h45: return 0*6 + 0;
            8'h1A: return 8*6 + 4;
            8'h3C: return 9*6 + 2;
            8'h46: return 0*6 + 1;
            8'h12: return 100;
            8'h59: return 101;
            8'h14: return 102;
            8'h11: return 104;
            8'h09: return 105;
            default: return -1;
        endcase
    endfunction

    function automatic void model_byte(logic [7:0] c, bit badp);
        int id;
        if (badp) begin
            mext = 0; mrel = 0;
        end else if (c == 8'hE0) mext = 1;
        else if (c == 8'hF0) mrel = 1;
        else if (c == 8'hAA || c == 8'hFA) mext = mext;
        else if (c == 8'h00 || c == 8'hFF) begin
            held.delete(); mext = 0; mrel = 0;
        end else begin
            id = lookup(mext, c);
            if (id >= 0) begin
                if (mrel) held.delete(id);
                else held[id] = 1;
            end
            mext = 0; mrel = 0;
        end
    endfunction

    function automatic logic [71:0] model_rows();
        logic [71:0] v;
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 6; c++)
                v[r*6 + c] = !(r <= 9 && held.exists(r*6 + c));
        return v;
    endfunction

    function automatic logic [3:0] model_mods();
        return {!(held.exists(100) || held.exists(101)), !(held.exists(102) || held.exists(103)),
                !held.exists(104), !held.exists(105)};
    endfunction

    task automatic tx(logic [7:0] c, bit badp);
        send(c, badp);
        model_byte(c, badp);
    endtask

    initial begin
        logic [71:0] rows;
        logic [7:0]  pool [16];
        int e0, k;
        pool = '{8'h1C, 8'h29, 8'h5A, 8'h32, 8'h45, 8'h1A, 8'h3C, 8'h46,
                 8'h12, 8'h59, 8'h14, 8'h11, 8'h09, 8'h75, 8'h6B, 8'h76};

        add(8'h1C, 0, 1, 6'b011111, 4'hF, 0);
        add(8'hF0, 0, 1, 6'b011111, 4'hF, 0);
        add(8'h1C, 0, 1, 6'b111111, 4'hF, 0);
        add(8'h12, 0, 1, 6'b111111, 4'b0111, 0);
        add(8'h59, 0, 1, 6'b111111, 4'b0111, 0);
        add(8'hF0, 0, 1, 6'b111111, 4'b0111, 0);
        add(8'h12, 0, 1, 6'b111111, 4'b0111, 0);
        add(8'hF0, 0, 1, 6'b111111, 4'b0111, 0);
        add(8'h59, 0, 1, 6'b111111, 4'hF, 0);
        add(8'h29, 1, 9, 6'b111111, 4'hF, 1);
        add(8'h14, 0, 9, 6'b111111, 4'b1011, 0);
        add(8'h11, 0, 9, 6'b111111, 4'b1001, 0);
        add(8'hF0, 0, 9, 6'b111111, 4'b1001, 0);
        add(8'h14, 0, 9, 6'b111111, 4'b1101, 0);
        add(8'hF0, 0, 9, 6'b111111, 4'b1101, 0);
        add(8'h11, 0, 9, 6'b111111, 4'hF, 0);
        add(8'h5A, 0, 6, 6'b111101, 4'hF, 0);
        add(8'h5A, 0, 6, 6'b111101, 4'hF, 0);
        add(8'hAA, 0, 6, 6'b111101, 4'hF, 0);
        add(8'hFA, 0, 6, 6'b111101, 4'hF, 0);
        add(8'h5A, 0, 12, 6'b111111, 4'hF, 0);
        add(8'hF0, 0, 6, 6'b111101, 4'hF, 0);
        add(8'h5A, 0, 6, 6'b111111, 4'hF, 0);
        add(8'hF0, 0, 6, 6'b111111, 4'hF, 0);
        add(8'h5A, 0, 6, 6'b111111, 4'hF, 0);
        add(8'h29, 0, 9, 6'b111110, 4'hF, 0);
        add(8'h45, 0, 0, 6'b111110, 4'hF, 0);
        add(8'hF0, 0, 0, 6'b111110, 4'hF, 0);
        add(8'h1C, 1, 0, 6'b111110, 4'hF, 1);
        add(8'h1C, 0, 1, 6'b011111, 4'hF, 0);
        add(8'h00, 0, 1, 6'b111111, 4'hF, 0);
        add(8'hFA, 0, 9, 6'b111111, 4'hF, 0);
        add(8'hE0, 0, 3, 6'b111111, 4'hF, 0);
        add(8'h75, 0, 3, EXT ? 6'b011111 : 6'b111111, 4'hF, 0);
        add(8'hE0, 0, 3, EXT ? 6'b011111 : 6'b111111, 4'hF, 0);
        add(8'h14, 0, 3, EXT ? 6'b011111 : 6'b111111, EXT ? 4'b1011 : 4'hF, 0);
        add(8'hE0, 0, 3, EXT ? 6'b011111 : 6'b111111, EXT ? 4'b1011 : 4'hF, 0);
        add(8'hF0, 0, 3, EXT ? 6'b011111 : 6'b111111, EXT ? 4'b1011 : 4'hF, 0);
        add(8'h75, 0, 3, 6'b111111, EXT ? 4'b1011 : 4'hF, 0);
        add(8'hE0, 0, 3, 6'b111111, EXT ? 4'b1011 : 4'hF, 0);
        add(8'hF0, 0, 3, 6'b111111, EXT ? 4'b1011 : 4'hF, 0);
        add(8'h14, 0, 3, 6'b111111, 4'hF, 0);
        add(8'h14, 0, 3, 6'b111111, 4'b1011, 0);
        add(8'hF0, 0, 3, 6'b111111, 4'b1011, 0);
        add(8'h14, 0, 3, 6'b111111, 4'hF, 0);

        cyc(3);
        read_rows(rows);
        chk("reset rows", rows, {72{1'b1}});
        chk("reset mods", {shift_n, ctrl_n, rept_n, break_n}, 4'hF);
        chk("reset frame_err", frame_err, 1'b0);
        reset_n = 1'b1;
        cyc(3);

        for (int i = 0; i < tbl.size(); i++) begin
            e0 = err_seen;
            send(tbl[i].code, tbl[i].badp);
            row = tbl[i].r;
            #1;
            chk($sformatf("vec%0d kb", i), keyboard, tbl[i].kb);
            chk($sformatf("vec%0d mods", i), {shift_n, ctrl_n, rept_n, break_n}, tbl[i].mods);
            chk($sformatf("vec%0d frame_err", i), err_seen - e0, tbl[i].errd);
            cyc(1);
        end

        e0 = err_seen;
        send(8'h29, 0, 5);
        cyc(2100);
        send(8'h29);
        row = 4'd9;
        #1;
        chk("timeout row9", keyboard, 6'b111110);
        chk("timeout frame_err", err_seen - e0, 0);
        cyc(1);
        send(8'hF0);
        send(8'h29);

        send(8'h09);
        #1;
        chk("break held", break_n, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("break async reset", break_n, 1'b1);
        read_rows(rows);
        chk("rows in reset", rows, {72{1'b1}});
        reset_n = 1'b1;
        cyc(3);

        send(8'h1C, 0, 4);
        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
        send(8'h1C);
        row = 4'd1;
        #1;
        chk("resync after reset", keyboard, 6'b011111);
        cyc(1);

        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
        held.delete();
        mext = 0;
        mrel = 0;
        for (int i = 0; i < 120; i++) begin
            e0 = err_seen;
            k = $urandom_range(0, 99);
            if (k < 8) tx(pool[$urandom_range(0, 15)], 1);
            else if (k < 12) tx(($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFA, 0);
            else if (k < 14) tx(8'h00, 0);
            else begin
                if ($urandom_range(0, 3) == 0) tx(8'hE0, 0);
                if ($urandom_range(0, 9) < 4) tx(8'hF0, 0);
                tx(pool[$urandom_range(0, 15)], 0);
            end
            read_rows(rows);
            chk($sformatf("rand%0d rows", i), rows, model_rows());
            chk($sformatf("rand%0d mods", i), {shift_n, ctrl_n, rept_n, break_n}, model_mods());
            chk($sformatf("rand%0d frame_err", i), err_seen - e0, (k < 8) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
